// File: rtl/fp_mac_pkg.sv
// Shared types and constants for the floating-point MAC sequencer.
package fp_mac_pkg;

  localparam int MAX_LEN_DEF = 16;
  localparam int ADDR_W_DEF  = 4;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_LATCH     = 3'd2,
    S_MUL_ISSUE = 3'd3,
    S_MUL_WAIT  = 3'd4,
    S_ADD_ISSUE = 3'd5,
    S_ADD_WAIT  = 3'd6,
    S_DONE      = 3'd7
  } state_t;

endpackage

// File: rtl/axis_src_slot.sv
// One AXI-Stream source beat: captures data on a load pulse, presents it
// until the consumer accepts it, and reports acceptance through done.
module axis_src_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         tready,
  output logic         tvalid,
  output logic [W-1:0] tdata,
  output logic         done
);

  logic accepted_r;

  // Hold the beat stable until accepted, then remember that it went out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid     <= 1'b0;
      tdata      <= {W{1'b0}};
      accepted_r <= 1'b0;
    end else if (load) begin
      tvalid     <= 1'b1;
      tdata      <= load_data;
      accepted_r <= 1'b0;
    end else if (tvalid && tready) begin
      tvalid     <= 1'b0;
      accepted_r <= 1'b1;
    end
  end

  // done also covers the accepting cycle so the issuer can leave without a bubble
  assign done = accepted_r | (tvalid & tready);

endmodule

// File: rtl/fp_mac_sequencer.sv
// Sequencer computing y = bias + sum(w[i]*x[i]) by time-sharing one fp32
// multiplier and one fp32 adder over AXI-Stream channels. Accumulation is
// strictly in index order so results match a scalar reference bit-exactly.
module fp_mac_sequencer
  import fp_mac_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [31:0]       bias,
  output logic              op_rd,
  output logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       w_data,
  input  logic [31:0]       x_data,
  output logic              mul_a_tvalid,
  input  logic              mul_a_tready,
  output logic [31:0]       mul_a_tdata,
  output logic              mul_b_tvalid,
  input  logic              mul_b_tready,
  output logic [31:0]       mul_b_tdata,
  input  logic              mul_r_tvalid,
  output logic              mul_r_tready,
  input  logic [31:0]       mul_r_tdata,
  output logic              add_a_tvalid,
  input  logic              add_a_tready,
  output logic [31:0]       add_a_tdata,
  output logic              add_b_tvalid,
  input  logic              add_b_tready,
  output logic [31:0]       add_b_tdata,
  input  logic              add_r_tvalid,
  output logic              add_r_tready,
  input  logic [31:0]       add_r_tdata,
  output logic              busy,
  output logic [31:0]       result,
  output logic              result_valid,
  input  logic              result_ready
);

  state_t              state_r;
  logic [ADDR_W:0]     len_r;
  logic [ADDR_W:0]     len_clamped;
  logic [ADDR_W-1:0]   idx_r;
  logic [31:0]         acc_r;
  logic                mul_load;
  logic                add_load;
  logic                mul_a_done;
  logic                mul_b_done;
  logic                add_a_done;
  logic                add_b_done;
  logic                last_elem;

  // Clamp the requested length to the operand memory depth
  always_comb begin
    if (len > (ADDR_W+1)'(MAX_LEN)) begin
      len_clamped = (ADDR_W+1)'(MAX_LEN);
    end else begin
      len_clamped = len;
    end
  end

  // Operands arrive in LATCH; the product arrives on the multiplier result handshake
  assign mul_load  = (state_r == S_LATCH);
  assign add_load  = (state_r == S_MUL_WAIT) && mul_r_tvalid && mul_r_tready;
  assign last_elem = ({1'b0, idx_r} == (len_r - (ADDR_W+1)'(1)));

  axis_src_slot #(.W(32)) u_mul_a (
    .clk(clk), .rst_n(rst_n), .load(mul_load), .load_data(w_data),
    .tready(mul_a_tready), .tvalid(mul_a_tvalid), .tdata(mul_a_tdata), .done(mul_a_done)
  );

  axis_src_slot #(.W(32)) u_mul_b (
    .clk(clk), .rst_n(rst_n), .load(mul_load), .load_data(x_data),
    .tready(mul_b_tready), .tvalid(mul_b_tvalid), .tdata(mul_b_tdata), .done(mul_b_done)
  );

  axis_src_slot #(.W(32)) u_add_a (
    .clk(clk), .rst_n(rst_n), .load(add_load), .load_data(acc_r),
    .tready(add_a_tready), .tvalid(add_a_tvalid), .tdata(add_a_tdata), .done(add_a_done)
  );

  axis_src_slot #(.W(32)) u_add_b (
    .clk(clk), .rst_n(rst_n), .load(add_load), .load_data(mul_r_tdata),
    .tready(add_b_tready), .tvalid(add_b_tvalid), .tdata(add_b_tdata), .done(add_b_done)
  );

  // Main sequencing FSM with registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      len_r        <= (ADDR_W+1)'(0);
      idx_r        <= ADDR_W'(0);
      acc_r        <= FP_ZERO;
      op_rd        <= 1'b0;
      op_addr      <= ADDR_W'(0);
      mul_r_tready <= 1'b0;
      add_r_tready <= 1'b0;
      busy         <= 1'b0;
      result       <= FP_ZERO;
      result_valid <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            len_r <= len_clamped;
            acc_r <= bias;
            idx_r <= ADDR_W'(0);
            busy  <= 1'b1;
            if (len_clamped == (ADDR_W+1)'(0)) begin
              result       <= bias;
              result_valid <= 1'b1;
              state_r      <= S_DONE;
            end else begin
              op_rd   <= 1'b1;
              op_addr <= ADDR_W'(0);
              state_r <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          op_rd   <= 1'b0;
          state_r <= S_LATCH;
        end
        S_LATCH: begin
          state_r <= S_MUL_ISSUE;
        end
        S_MUL_ISSUE: begin
          if (mul_a_done && mul_b_done) begin
            mul_r_tready <= 1'b1;
            state_r      <= S_MUL_WAIT;
          end
        end
        S_MUL_WAIT: begin
          if (mul_r_tvalid) begin
            mul_r_tready <= 1'b0;
            state_r      <= S_ADD_ISSUE;
          end
        end
        S_ADD_ISSUE: begin
          if (add_a_done && add_b_done) begin
            add_r_tready <= 1'b1;
            state_r      <= S_ADD_WAIT;
          end
        end
        S_ADD_WAIT: begin
          if (add_r_tvalid) begin
            add_r_tready <= 1'b0;
            acc_r        <= add_r_tdata;
            if (last_elem) begin
              result       <= add_r_tdata;
              result_valid <= 1'b1;
              state_r      <= S_DONE;
            end else begin
              idx_r   <= idx_r + ADDR_W'(1);
              op_addr <= idx_r + ADDR_W'(1);
              op_rd   <= 1'b1;
              state_r <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state_r      <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mac_sequencer.sv
// Self-checking bench for fp_mac_sequencer: behavioural fp32 cores and
// operand memories, table-driven vectors, plus stall and reset sequences.
module tb_fp_mac_sequencer;
  import fp_mac_pkg::*;

  localparam int ML = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic [31:0]   bias = '0;
  logic          op_rd;
  logic [AW-1:0] op_addr;
  logic [31:0]   w_data = '0, x_data = '0;
  logic          mul_a_tvalid, mul_a_tready, mul_b_tvalid, mul_b_tready;
  logic [31:0]   mul_a_tdata, mul_b_tdata, mul_r_tdata;
  logic          mul_r_tvalid, mul_r_tready;
  logic          add_a_tvalid, add_a_tready, add_b_tvalid, add_b_tready;
  logic [31:0]   add_a_tdata, add_b_tdata, add_r_tdata;
  logic          add_r_tvalid, add_r_tready;
  logic          busy, result_valid;
  logic          result_ready = 1'b0;
  logic [31:0]   result;

  int checks = 0;
  int errors = 0;
  logic bp_mode = 1'b0;
  logic [31:0] sb[$];

  fp_mac_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bias(bias),
    .op_rd(op_rd), .op_addr(op_addr), .w_data(w_data), .x_data(x_data),
    .mul_a_tvalid(mul_a_tvalid), .mul_a_tready(mul_a_tready), .mul_a_tdata(mul_a_tdata),
    .mul_b_tvalid(mul_b_tvalid), .mul_b_tready(mul_b_tready), .mul_b_tdata(mul_b_tdata),
    .mul_r_tvalid(mul_r_tvalid), .mul_r_tready(mul_r_tready), .mul_r_tdata(mul_r_tdata),
    .add_a_tvalid(add_a_tvalid), .add_a_tready(add_a_tready), .add_a_tdata(add_a_tdata),
    .add_b_tvalid(add_b_tvalid), .add_b_tready(add_b_tready), .add_b_tdata(add_b_tdata),
    .add_r_tvalid(add_r_tvalid), .add_r_tready(add_r_tready), .add_r_tdata(add_r_tdata),
    .busy(busy), .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  // fp32 <-> real for normal numbers and zero (all vectors stay exact)
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Operand memories: data one cycle after the read strobe
  logic [31:0] wmem [ML];
  logic [31:0] xmem [ML];
  always @(posedge clk) begin
    if (op_rd) begin
      w_data <= wmem[op_addr];
      x_data <= xmem[op_addr];
    end
  end

  // Multiplier model; in backpressure mode b is random and a waits >=3 cycles after b
  logic [31:0] ma, mb;
  logic ma_got, mb_got;
  int mb_age;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_got <= 1'b0; mb_got <= 1'b0; mb_age <= 0;
      mul_r_tvalid <= 1'b0; mul_r_tdata <= '0;
      mul_a_tready <= 1'b0; mul_b_tready <= 1'b0;
    end else begin
      if (mul_a_tvalid && mul_a_tready) begin ma <= mul_a_tdata; ma_got <= 1'b1; end
      if (mul_b_tvalid && mul_b_tready) begin mb <= mul_b_tdata; mb_got <= 1'b1; end
      mb_age <= (mb_got && !ma_got) ? mb_age + 1 : 0;
      if (ma_got && mb_got && !mul_r_tvalid) begin
        mul_r_tvalid <= 1'b1;
        mul_r_tdata  <= r2f(f2r(ma) * f2r(mb));
        ma_got <= 1'b0; mb_got <= 1'b0;
      end else if (mul_r_tvalid && mul_r_tready) begin
        mul_r_tvalid <= 1'b0;
      end
      if (bp_mode) begin
        mul_b_tready <= ($urandom_range(0, 1) == 1);
        mul_a_tready <= (mb_age >= 3) && ($urandom_range(0, 1) == 1);
      end else begin
        mul_a_tready <= 1'b1; mul_b_tready <= 1'b1;
      end
    end
  end

  // Adder model; random ready in backpressure mode
  logic [31:0] aa, ab;
  logic aa_got, ab_got;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aa_got <= 1'b0; ab_got <= 1'b0;
      add_r_tvalid <= 1'b0; add_r_tdata <= '0;
      add_a_tready <= 1'b0; add_b_tready <= 1'b0;
    end else begin
      if (add_a_tvalid && add_a_tready) begin aa <= add_a_tdata; aa_got <= 1'b1; end
      if (add_b_tvalid && add_b_tready) begin ab <= add_b_tdata; ab_got <= 1'b1; end
      if (aa_got && ab_got && !add_r_tvalid) begin
        add_r_tvalid <= 1'b1;
        add_r_tdata  <= r2f(f2r(aa) + f2r(ab));
        aa_got <= 1'b0; ab_got <= 1'b0;
      end else if (add_r_tvalid && add_r_tready) begin
        add_r_tvalid <= 1'b0;
      end
      add_a_tready <= bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      add_b_tready <= bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitors: handshake counts, any-tvalid cycles, read addresses, stalled-beat stability
  int mul_a_n = 0, mul_b_n = 0, add_a_n = 0, add_b_n = 0, tv_cycles = 0, stab_viol = 0;
  logic [AW-1:0] addr_log[$];
  logic [3:0] vv, rr, stall_prev;
  logic [31:0] dd [4];
  logic [31:0] dprev [4];
  assign vv = {add_b_tvalid, add_a_tvalid, mul_b_tvalid, mul_a_tvalid};
  assign rr = {add_b_tready, add_a_tready, mul_b_tready, mul_a_tready};
  assign dd[0] = mul_a_tdata;
  assign dd[1] = mul_b_tdata;
  assign dd[2] = add_a_tdata;
  assign dd[3] = add_b_tdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_prev <= 4'd0;
    end else begin
      if (mul_a_tvalid && mul_a_tready) mul_a_n <= mul_a_n + 1;
      if (mul_b_tvalid && mul_b_tready) mul_b_n <= mul_b_n + 1;
      if (add_a_tvalid && add_a_tready) add_a_n <= add_a_n + 1;
      if (add_b_tvalid && add_b_tready) add_b_n <= add_b_n + 1;
      if (vv != 4'd0) tv_cycles <= tv_cycles + 1;
      if (op_rd) addr_log.push_back(op_addr);
      for (int c = 0; c < 4; c++) begin
        if (stall_prev[c] && (!vv[c] || dd[c] !== dprev[c])) stab_viol <= stab_viol + 1;
        dprev[c] <= dd[c];
      end
      stall_prev <= vv & ~rr;
    end
  end

  typedef struct {
    logic [AW:0]            len;
    logic [31:0]            bias;
    logic [ML-1:0][31:0]    w;
    logic [ML-1:0][31:0]    x;
    logic                   bp;
    logic [31:0]            exp;
  } vec_t;

  vec_t tv [7];

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < ML; i++) begin
      wmem[i] = v.w[i];
      xmem[i] = v.x[i];
    end
    bp_mode = v.bp;
  endtask

  task automatic wait_rv(input string name);
    int k;
    k = 0;
    while (!result_valid && k < 3000) begin @(posedge clk); #1; k++; end
    check(name, result_valid, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    int n, lat, b_ma, b_mb, b_aa, b_ab, b_tv, b_sv, b_addr;
    logic [31:0] e;
    n = (v.len > 5'd16) ? 16 : int'(v.len);
    load_vec(v);
    sb.push_back(v.exp);
    b_ma = mul_a_n; b_mb = mul_b_n; b_aa = add_a_n; b_ab = add_b_n;
    b_tv = tv_cycles; b_sv = stab_viol; b_addr = addr_log.size();
    start = 1'b1; len = v.len; bias = v.bias;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", busy, 1'b1);
    lat = 1;
    while (!result_valid && lat < 3000) begin @(posedge clk); #1; lat++; end
    check("result_valid_seen", result_valid, 1'b1);
    if (n == 0) check("len0_latency_le2", (lat <= 2), 1'b1);
    result_ready = 1'b1;
    e = sb.pop_front();
    check("result", result, e);
    @(posedge clk); #1;
    result_ready = 1'b0;
    check("busy_fall", busy, 1'b0);
    check("result_valid_fall", result_valid, 1'b0);
    check("mul_a_issues", mul_a_n - b_ma, n);
    check("mul_b_issues", mul_b_n - b_mb, n);
    check("add_a_issues", add_a_n - b_aa, n);
    check("add_b_issues", add_b_n - b_ab, n);
    check("addr_count", addr_log.size() - b_addr, n);
    for (int i = 0; i < n && b_addr + i < addr_log.size(); i++)
      check("op_addr_sweep", 32'(addr_log[b_addr + i]), i);
    check("tvalid_stable", stab_viol - b_sv, 0);
    if (n == 0) check("len0_no_tvalid", tv_cycles - b_tv, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mul_a_tvalid"}, mul_a_tvalid, 1'b0);
    check({tag, "_mul_b_tvalid"}, mul_b_tvalid, 1'b0);
    check({tag, "_add_a_tvalid"}, add_a_tvalid, 1'b0);
    check({tag, "_add_b_tvalid"}, add_b_tvalid, 1'b0);
    check({tag, "_mul_r_tready"}, mul_r_tready, 1'b0);
    check({tag, "_add_r_tready"}, add_r_tready, 1'b0);
    check({tag, "_op_rd"}, op_rd, 1'b0);
    check({tag, "_op_addr"}, 32'(op_addr), 0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_result_valid"}, result_valid, 1'b0);
    check({tag, "_result"}, result, 32'h0000_0000);
  endtask

  initial begin
    int k;
    logic [31:0] e;
    for (int v = 0; v < 7; v++) begin
      tv[v].w = '0; tv[v].x = '0; tv[v].bp = 1'b0; tv[v].bias = 32'h0; tv[v].len = 5'd0;
    end
    // basic: 0.5 + 1*3 + 2*0.5 = 4.5
    tv[0].len = 5'd2; tv[0].bias = 32'h3F00_0000;
    tv[0].w[0] = 32'h3F80_0000; tv[0].w[1] = 32'h4000_0000;
    tv[0].x[0] = 32'h4040_0000; tv[0].x[1] = 32'h3F00_0000;
    tv[0].exp = 32'h4090_0000;
    tv[1] = tv[0]; tv[1].bp = 1'b1;
    // sixteen ones -> 16.0
    for (int i = 0; i < ML; i++) begin
      tv[2].w[i] = 32'h3F80_0000; tv[2].x[i] = 32'h3F80_0000;
    end
    tv[2].len = 5'd16; tv[2].exp = 32'h4180_0000;
    // empty vector returns the bias
    tv[3].len = 5'd0; tv[3].bias = 32'h4040_0000; tv[3].exp = 32'h4040_0000;
    // -1 + 2*3 = 5.0
    tv[4].len = 5'd1; tv[4].bias = 32'hBF80_0000;
    tv[4].w[0] = 32'h4000_0000; tv[4].x[0] = 32'h4040_0000; tv[4].exp = 32'h40A0_0000;
    // 0 + 1*0.5 - 2*1 + 4*0.25 = -0.5
    tv[5].len = 5'd3;
    tv[5].w[0] = 32'h3F80_0000; tv[5].w[1] = 32'hC000_0000; tv[5].w[2] = 32'h4080_0000;
    tv[5].x[0] = 32'h3F00_0000; tv[5].x[1] = 32'h3F80_0000; tv[5].x[2] = 32'h3E80_0000;
    tv[5].exp = 32'hBF00_0000;
    // len 20 clamps to 16: 1 + 16 = 17.0
    tv[6] = tv[2]; tv[6].len = 5'd20; tv[6].bias = 32'h3F80_0000; tv[6].exp = 32'h4188_0000;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) run_vec(tv[v]);

    // result_ready held low 10 cycles with a start pulse during DONE
    load_vec(tv[0]);
    sb.push_back(tv[0].exp);
    start = 1'b1; len = tv[0].len; bias = tv[0].bias;
    @(posedge clk); #1;
    start = 1'b0;
    wait_rv("stall_rv_seen");
    k = addr_log.size();
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin start = 1'b1; len = 5'd1; bias = 32'h4120_0000; end
      else start = 1'b0;
      @(posedge clk); #1;
      check("stall_result_stable", result, sb[0]);
      check("stall_result_valid", result_valid, 1'b1);
      check("stall_busy", busy, 1'b1);
    end
    start = 1'b0;
    result_ready = 1'b1;
    e = sb.pop_front();
    check("stall_result", result, e);
    @(posedge clk); #1;
    result_ready = 1'b0;
    check("stall_busy_fall", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("ignored_start_idle", busy, 1'b0);
    check("ignored_start_no_read", addr_log.size() - k, 0);

    // asynchronous reset while waiting on the adder
    load_vec(tv[0]);
    start = 1'b1; len = tv[0].len; bias = tv[0].bias;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!add_r_tready && k < 200) begin @(posedge clk); #1; k++; end
    check("reached_add_wait", add_r_tready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(tv[0]);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
